// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Serial receive front end: synchronises ser_rx_i, recovers 8N1 frames by
//   mid-bit oversampling on the core clock and buffers received bytes in a
//   show-ahead FIFO read through a valid/ready handshake.
//
// Ports
//   clk_i        core clock
//   rst_i        asynchronous active-high reset
//   ser_rx_i     asynchronous serial input, idle high
//   rdata_o      head-of-FIFO byte (valid while rvalid_o)
//   rvalid_o     FIFO not empty
//   rready_i     consumer pop request (pop = rvalid_o & rready_i)
//   frame_err_o  one-cycle pulse when a stop bit samples 0
//   overrun_o    sticky; good byte arrived while FIFO full with no pop
//   clear_i      clears overrun_o (FIFO untouched)
//   busy_o       receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ser_rx_i,
    output logic [7:0] rdata_o,
    output logic       rvalid_o,
    input  logic       rready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clear_i,
    output logic       busy_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned ADDR_W       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_baud
        $fatal(1, "uart_rx_fifo: CLK_FREQ/BAUDRATE must be at least 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge history (all reset to idle-high level)
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_rx_s;
    logic r_rx_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= ser_rx_i;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame recovery FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_push;
    logic             r_frame_err;
    logic             w_expire;

    assign w_expire = (r_cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_HALF;
                    end
                end
                S_START: begin
                    if (w_expire) begin
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                            r_cnt   <= CNT_BIT;
                            r_idx   <= '0;
                        end else begin
                            // Start bit gone high by mid-bit: treat as glitch.
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_expire) begin
                        r_shift[r_idx] <= r_rx_s;
                        r_cnt          <= CNT_BIT;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_expire) begin
                        if (r_rx_s) begin
                            r_push  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    // Break / stuck-low line: one error, then wait for idle.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO. r_shift still holds the completed byte in the cycle
    // r_push is high (the next DATA phase is at least half a bit away),
    // so it is used directly as the write data.
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [7:0]      r_rdata;
    logic            r_overrun;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;
    logic            w_ovf;
    logic [ADDR_W:0] w_wr_ptr_nxt;
    logic [ADDR_W:0] w_rd_ptr_nxt;
    logic [7:0]      w_head_nxt;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                          (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop        = rready_i && !w_empty;
    // Pop is evaluated first, so a full FIFO with a pop still accepts a push.
    assign w_wr_en      = r_push && (!w_full || w_pop);
    assign w_ovf        = r_push && w_full && !w_pop;
    assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_en};
    assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop};

    // Next head: bypass the write data when it lands in the head slot.
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt[ADDR_W-1:0]];
        if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = r_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rdata   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if ((w_pop || w_wr_en) && (w_wr_ptr_nxt != w_rd_ptr_nxt)) begin
                r_rdata <= w_head_nxt;
            end
            if (w_ovf) begin
                r_overrun <= 1'b1;
            end else if (clear_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rdata_o     = r_rdata;
    assign rvalid_o    = !w_empty;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int unsigned BIT_NS = 8680;   // 217 clocks of 40 ns
    localparam int unsigned CPB    = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_rx = 1'b1;
    logic       rready = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_fifo #(
        .CLK_FREQ   (25_000_000),
        .BAUDRATE   (115200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ser_rx_i    (ser_rx),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .clear_i     (clear),
        .busy_o      (busy)
    );

    always #20 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycles with frame_err high; a correct one-cycle pulse adds exactly one.
    int unsigned ferr_cnt = 0;
    always @(negedge clk) if (frame_err) ferr_cnt = ferr_cnt + 1;

    logic        rv_q = 1'b0;
    int unsigned rise_cyc = 0;
    always @(negedge clk) begin
        if (rvalid && !rv_q) rise_cyc = cyc;
        rv_q = rvalid;
    end

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned start_cyc = 0;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        exp_valid;
        logic [7:0]  exp_data;
        int unsigned exp_ferr;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; the line then stays at the
    // stop level for tail_bits more bit times before returning high.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned tail_bits);
        @(negedge clk);
        ser_rx = 1'b0;
        start_cyc = cyc;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            ser_rx = d[i];
            #BIT_NS;
        end
        ser_rx = stop;
        #BIT_NS;
        repeat (tail_bits) #BIT_NS;
        ser_rx = 1'b1;
    endtask

    task automatic pop_one();
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wait_not_busy(input int unsigned budget, input string name);
        int unsigned n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f0;
        int unsigned lat;
        logic [7:0]  exp_q [4];
        logic [7:0]  c3;
        int unsigned n;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 0};
        vecs[1] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        vecs[4] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1};
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst rvalid", rvalid, 0);
        check("rst rdata", rdata, 0);
        check("rst frame_err", frame_err, 0);
        check("rst overrun", overrun, 0);
        check("rst busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post-rst busy", busy, 0);

        // Single byte latency and pop
        send_frame(8'h68, 1'b1, 0);
        @(negedge clk);
        lat = rise_cyc - start_cyc;
        // 2 sync + 1 edge + 108 half bit + 1953 (9 bits) + 1 push = 2065;
        // window also spans the quoted 2061 +/- 1 nominal.
        check("latency in window", (lat >= 2060 && lat <= 2066) ? 32'd1 : 32'd0, 1);
        if (!(lat >= 2060 && lat <= 2066)) $display("  latency measured %0d cycles", lat);
        check("t1 rvalid", rvalid, 1);
        check("t1 rdata", rdata, 8'h68);
        pop_one();
        check("t1 empty after pop", rvalid, 0);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, 0);
            @(negedge clk);
            check($sformatf("tbl%0d rvalid", i), rvalid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check($sformatf("tbl%0d rdata", i), rdata, vecs[i].exp_data);
            check($sformatf("tbl%0d ferr pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
            if (rvalid) pop_one();
            check($sformatf("tbl%0d empty", i), rvalid, 0);
        end

        // Short low glitch: rejected at the mid-start sample
        f0 = ferr_cnt;
        @(negedge clk);
        ser_rx = 1'b0;
        start_cyc = cyc;
        repeat (50) @(negedge clk);
        ser_rx = 1'b1;
        check("glitch busy during", busy, 1);
        wait_not_busy(300, "glitch busy falls");
        check("glitch busy fall cycle", cyc - start_cyc, 3 + CPB / 2);
        repeat (CPB * 2) @(negedge clk);
        check("glitch rvalid", rvalid, 0);
        check("glitch ferr", ferr_cnt - f0, 0);

        // Bad stop followed by held-low line, then a good frame
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, 3);
        repeat (5) @(negedge clk);
        check("break ferr pulses", ferr_cnt - f0, 1);
        check("break rvalid", rvalid, 0);
        check("break busy", busy, 0);
        send_frame(8'h42, 1'b1, 0);
        @(negedge clk);
        check("after break rvalid", rvalid, 1);
        check("after break rdata", rdata, 8'h42);
        check("after break ferr", ferr_cnt - f0, 1);
        pop_one();

        // Overrun on the fifth byte, clear keeps contents
        exp_q = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
        for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1, 0);
        @(negedge clk);
        check("ovr before 5th", overrun, 0);
        send_frame(8'h3C, 1'b1, 0);
        @(negedge clk);
        check("ovr after 5th", overrun, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("ovr cleared", overrun, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovr q%0d rvalid", i), rvalid, 1);
            check($sformatf("ovr q%0d rdata", i), rdata, exp_q[i]);
            pop_one();
        end
        check("ovr drained", rvalid, 0);

        // Full FIFO, pop coincides with push
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1, 0);
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                n = 0;
                while (!busy && n < 300) begin @(negedge clk); n++; end
                n = 0;
                while (busy && n < 2500) begin @(negedge clk); n++; end
                check("full+pop busy fell", busy, 0);
                rready = 1'b1;
                check("full+pop rdata0", rdata, 8'h11);
                @(negedge clk);
                check("full+pop rdata1", rdata, 8'h22);
                @(negedge clk);
                check("full+pop rdata2", rdata, 8'h33);
                @(negedge clk);
                check("full+pop rdata3", rdata, 8'h44);
                @(negedge clk);
                check("full+pop rdata4", rdata, 8'h55);
                check("full+pop rvalid4", rvalid, 1);
                @(negedge clk);
                rready = 1'b0;
                check("full+pop empty", rvalid, 0);
                check("full+pop overrun", overrun, 0);
            end
        join

        // Reset in the middle of data bit 4
        send_frame(8'h9C, 1'b1, 0);
        @(negedge clk);
        check("pre-rst rvalid", rvalid, 1);
        c3 = 8'hC3;
        @(negedge clk);
        ser_rx = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            ser_rx = c3[i];
            #BIT_NS;
        end
        ser_rx = c3[4];
        #(BIT_NS / 2 + 10);
        check("mid-frame busy", busy, 1);
        f0 = ferr_cnt;
        rst = 1'b1;
        #1;
        check("async rst rvalid", rvalid, 0);
        check("async rst rdata", rdata, 0);
        check("async rst busy", busy, 0);
        check("async rst frame_err", frame_err, 0);
        check("async rst overrun", overrun, 0);
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (CPB * 5) @(negedge clk);
        check("rest of frame rvalid", rvalid, 0);
        check("rest of frame busy", busy, 0);
        check("rest of frame ferr", ferr_cnt - f0, 0);
        send_frame(8'h31, 1'b1, 0);
        @(negedge clk);
        check("post-rst frame rvalid", rvalid, 1);
        check("post-rst frame rdata", rdata, 8'h31);
        pop_one();
        check("post-rst frame empty", rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
